// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: drives key-schedule writes into the round-key memory
// and steps the round datapath through one block encryption per start request.
module aes_round_ctrl #(
    parameter int unsigned NR     = 10,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              new_key,
    input  logic              start,
    output logic              key_valid,
    output logic              busy,
    output logic              done,
    output logic              req_err,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic              kx_load,
    output logic              kx_step,
    output logic [ADDR_W-1:0] round,
    output logic              load_in,
    output logic              round_en,
    output logic              final_en,
    output logic              load_out
);

    localparam logic [ADDR_W-1:0] NR_A    = ADDR_W'(NR);
    localparam logic [ADDR_W-1:0] NR_M1_A = ADDR_W'(NR - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_KEXP, S_INIT, S_ROUND, S_FINAL, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              key_valid_q, key_valid_d;
    logic              busy_q, busy_d, done_q, done_d, req_err_q, req_err_d;
    logic              we_q, we_d, kx_load_q, kx_load_d, kx_step_q, kx_step_d;
    logic              load_in_q, load_in_d, round_en_q, round_en_d;
    logic              final_en_q, final_en_d, load_out_q, load_out_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d, round_q, round_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_err_q   <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            kx_load_q   <= 1'b0;
            kx_step_q   <= 1'b0;
            round_q     <= '0;
            load_in_q   <= 1'b0;
            round_en_q  <= 1'b0;
            final_en_q  <= 1'b0;
            load_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_err_q   <= req_err_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            kx_load_q   <= kx_load_d;
            kx_step_q   <= kx_step_d;
            round_q     <= round_d;
            load_in_q   <= load_in_d;
            round_en_q  <= round_en_d;
            final_en_q  <= final_en_d;
            load_out_q  <= load_out_d;
        end
    end

    // Next state, then outputs decoded from the next state so they register with it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_valid_d = key_valid_q;
        req_err_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        we_d        = 1'b0;
        waddr_d     = '0;
        raddr_d     = '0;
        kx_load_d   = 1'b0;
        kx_step_d   = 1'b0;
        round_d     = '0;
        load_in_d   = 1'b0;
        round_en_d  = 1'b0;
        final_en_d  = 1'b0;
        load_out_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (new_key) begin
                    state_d     = S_KEXP;
                    cnt_d       = '0;
                    key_valid_d = 1'b0;
                    req_err_d   = start;
                end else if (start) begin
                    if (key_valid_q) state_d = S_INIT;
                    else             req_err_d = 1'b1;
                end
            end
            S_KEXP: begin
                req_err_d = new_key | start;
                if (cnt_q == NR_A) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    key_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            S_INIT: begin
                req_err_d = new_key | start;
                if (NR > 1) begin
                    state_d = S_ROUND;
                    cnt_d   = ADDR_W'(1);
                end else begin
                    state_d = S_FINAL;
                    cnt_d   = NR_A;
                end
            end
            S_ROUND: begin
                req_err_d = new_key | start;
                if (cnt_q == NR_M1_A) state_d = S_FINAL;
                cnt_d = cnt_q + ADDR_W'(1);
            end
            S_FINAL: begin
                req_err_d = new_key | start;
                state_d   = S_DONE;
                cnt_d     = '0;
            end
            S_DONE: begin
                req_err_d = new_key | start;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_KEXP: begin
                we_d      = 1'b1;
                waddr_d   = cnt_d;
                round_d   = cnt_d;
                kx_load_d = (cnt_d == '0);
                kx_step_d = (cnt_d != '0);
            end
            S_INIT: begin
                load_in_d = 1'b1;
                raddr_d   = ADDR_W'(1);
            end
            S_ROUND: begin
                round_en_d = 1'b1;
                round_d    = cnt_d;
                raddr_d    = cnt_d + ADDR_W'(1);
            end
            S_FINAL: begin
                final_en_d = 1'b1;
                round_d    = NR_A;
            end
            S_DONE: begin
                done_d     = 1'b1;
                load_out_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign req_err   = req_err_q;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign raddr     = raddr_q;
    assign kx_load   = kx_load_q;
    assign kx_step   = kx_step_q;
    assign round     = round_q;
    assign load_in   = load_in_q;
    assign round_en  = round_en_q;
    assign final_en  = final_en_q;
    assign load_out  = load_out_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: directed scenarios then random requests/resets,
// each cycle checked against a schedule-queue reference model.
module tb_aes_round_ctrl;

    localparam int unsigned NR     = 10;
    localparam int unsigned ADDR_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0, new_key = 1'b0, start = 1'b0;
    logic key_valid, busy, done, req_err, we, kx_load, kx_step;
    logic load_in, round_en, final_en, load_out;
    logic [ADDR_W-1:0] waddr, raddr, round;

    aes_round_ctrl #(.NR(NR), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .new_key(new_key), .start(start),
        .key_valid(key_valid), .busy(busy), .done(done), .req_err(req_err),
        .we(we), .waddr(waddr), .raddr(raddr), .kx_load(kx_load),
        .kx_step(kx_step), .round(round), .load_in(load_in),
        .round_en(round_en), .final_en(final_en), .load_out(load_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              key_valid, busy, done, req_err, we;
        logic [ADDR_W-1:0] waddr, raddr;
        logic              kx_load, kx_step;
        logic [ADDR_W-1:0] round;
        logic              load_in, round_en, final_en, load_out;
    } obs_t;

    obs_t sched[$];   // outputs expected on the coming cycles of the current operation
    obs_t cur;        // outputs expected in the present cycle
    bit   kv;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference: an accepted request enqueues its whole output schedule.
    task automatic model_edge(input bit nk, input bit st, input bit rn);
        obs_t r;
        bit   rej;
        if (!rn) begin
            sched.delete();
            kv  = 1'b0;
            cur = '0;
            return;
        end
        rej = 1'b0;
        if (cur.busy) begin
            rej = nk | st;
            if (cur.we && cur.waddr == ADDR_W'(NR)) kv = 1'b1;
        end else if (nk) begin
            kv  = 1'b0;
            rej = st;
            for (int k = 0; k <= int'(NR); k++) begin
                r = '0; r.busy = 1'b1; r.we = 1'b1;
                r.waddr = ADDR_W'(k); r.round = ADDR_W'(k);
                r.kx_load = (k == 0); r.kx_step = (k != 0);
                sched.push_back(r);
            end
        end else if (st && kv) begin
            r = '0; r.busy = 1'b1; r.load_in = 1'b1; r.raddr = ADDR_W'(1);
            sched.push_back(r);
            for (int rd = 1; rd < int'(NR); rd++) begin
                r = '0; r.busy = 1'b1; r.round_en = 1'b1;
                r.round = ADDR_W'(rd); r.raddr = ADDR_W'(rd + 1);
                sched.push_back(r);
            end
            r = '0; r.busy = 1'b1; r.final_en = 1'b1; r.round = ADDR_W'(NR);
            sched.push_back(r);
            r = '0; r.busy = 1'b1; r.done = 1'b1; r.load_out = 1'b1;
            sched.push_back(r);
        end else if (st) begin
            rej = 1'b1;
        end
        if (sched.size() > 0) r = sched.pop_front();
        else                  r = '0;
        r.key_valid = kv;
        r.req_err   = rej;
        cur = r;
    endtask

    task automatic cyc(input bit nk, input bit st, input bit rn, input string tag);
        obs_t obs;
        new_key = nk;
        start   = st;
        rst_n   = rn;
        @(posedge clk);
        model_edge(nk, st, rn);
        #1;
        obs = '{key_valid, busy, done, req_err, we, waddr, raddr, kx_load,
                kx_step, round, load_in, round_en, final_en, load_out};
        n_cmp++;
        assert (obs === cur) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, cur);
        end
    endtask

    initial begin
        cur = '0;
        kv  = 1'b0;
        repeat (3) cyc(0, 0, 0, "reset");
        cyc(0, 0, 1, "idle_after_reset");
        cyc(0, 1, 1, "start_no_key");
        cyc(0, 0, 1, "after_reject");

        cyc(1, 0, 1, "new_key");
        repeat (12) cyc(0, 0, 1, "kexp");

        cyc(0, 1, 1, "start");
        repeat (11) cyc(0, 0, 1, "enc");
        cyc(0, 1, 1, "start_in_done");
        repeat (4) cyc(0, 0, 1, "no_second_enc");

        cyc(0, 1, 1, "start2");
        repeat (3) cyc(0, 0, 1, "enc2");
        cyc(1, 0, 1, "new_key_in_round");
        repeat (10) cyc(0, 0, 1, "enc2_tail");

        cyc(1, 1, 1, "new_key_and_start");
        repeat (12) cyc(0, 0, 1, "kexp2");

        cyc(0, 1, 1, "start3");
        repeat (5) cyc(0, 0, 1, "to_round5");
        cyc(0, 0, 0, "reset_mid_round");
        repeat (15) cyc(0, 0, 1, "after_abort");

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 249) != 0, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
